// File: rtl/wr_arb_pkg.sv
// Shared definitions for the two-requester write-port arbiter:
// default widths, FSM state encoding and a small grant-vector helper.
package wr_arb_pkg;

    localparam int DEF_SPI_WIDTH = 32;
    localparam int DEF_TAG_WIDTH = 4;
    localparam int DEF_MAX_BURST = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CFG     = 2'd1,
        ST_DATA    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // Requester index (0/1) to one-hot grant vector.
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/wr_arb_req_slot.sv
// One requester's configuration slot: holds the pending flag and the tag
// captured with the accepted config pulse. A pulse arriving while the slot
// is still pending is dropped and reported; a pulse arriving in the same
// cycle as the release clear re-arms the slot with the new tag.
module wr_arb_req_slot
    import wr_arb_pkg::*;
#(
    parameter int TAG_WIDTH = DEF_TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_cfg_pulse,
    input  logic [TAG_WIDTH-1:0] i_cfg_tag,
    input  logic                 i_clear,
    output logic                 o_pending,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic                 o_cfg_ready,
    output logic                 o_drop
);

    logic                 r_pending;
    logic [TAG_WIDTH-1:0] r_tag;
    logic                 w_accept;

    assign w_accept    = i_cfg_pulse && (!r_pending || i_clear);
    assign o_drop      = i_cfg_pulse && r_pending && !i_clear;
    assign o_pending   = r_pending;
    assign o_tag       = r_tag;
    assign o_cfg_ready = !r_pending;

    // Capture tag on an accepted pulse, drop pending when the owner releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_tag     <= '0;
        end else if (w_accept) begin
            r_pending <= 1'b1;
            r_tag     <= i_cfg_tag;
        end else if (i_clear) begin
            r_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/wr_port_arbiter.sv
// Arbitrates two requesters onto one shared write FIFO. A requester first
// posts a config tag; the arbiter grants it (round-robin on contention),
// forwards the tag as a single config pulse, then passes its data stream
// through combinationally until the last word or MAX_BURST words.
module wr_port_arbiter
    import wr_arb_pkg::*;
#(
    parameter int SPI_WIDTH = DEF_SPI_WIDTH,
    parameter int TAG_WIDTH = DEF_TAG_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_pulse_0,
    input  logic                 cfg_pulse_1,
    input  logic [TAG_WIDTH-1:0] cfg_tag_0,
    input  logic [TAG_WIDTH-1:0] cfg_tag_1,
    output logic                 cfg_ready_0,
    output logic                 cfg_ready_1,
    input  logic                 wr_req_0,
    input  logic                 wr_req_1,
    input  logic [SPI_WIDTH-1:0] wr_data_0,
    input  logic [SPI_WIDTH-1:0] wr_data_1,
    input  logic                 wr_last_0,
    input  logic                 wr_last_1,
    output logic                 wr_ready_0,
    output logic                 wr_ready_1,
    input  logic                 config_ready,
    output logic                 config_paulse,
    output logic [TAG_WIDTH-1:0] config_data,
    input  logic                 wr_ready,
    output logic                 wr_req,
    output logic [SPI_WIDTH-1:0] wr_data,
    output logic [1:0]           grant,
    output logic                 drop_err
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t           r_state, w_state_next;
    logic                 r_owner, w_owner_next;
    logic                 r_ptr, w_ptr_next;
    logic [CNT_W-1:0]     r_count, w_count_next;
    logic                 r_drop_err;

    logic                 w_cfg_pulse [2];
    logic [TAG_WIDTH-1:0] w_cfg_tag   [2];
    logic [TAG_WIDTH-1:0] w_tag       [2];
    logic [1:0]           w_pending;
    logic [1:0]           w_cfg_ready;
    logic [1:0]           w_drop;
    logic [1:0]           w_clear;

    logic                 w_in_cfg, w_in_data;
    logic                 w_req_g, w_last_g, w_xfer;
    logic [SPI_WIDTH-1:0] w_data_g;

    assign w_cfg_pulse[0] = cfg_pulse_0;
    assign w_cfg_pulse[1] = cfg_pulse_1;
    assign w_cfg_tag[0]   = cfg_tag_0;
    assign w_cfg_tag[1]   = cfg_tag_1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            wr_arb_req_slot #(
                .TAG_WIDTH (TAG_WIDTH)
            ) u_slot (
                .clk         (clk),
                .rst         (rst),
                .i_cfg_pulse (w_cfg_pulse[gi]),
                .i_cfg_tag   (w_cfg_tag[gi]),
                .i_clear     (w_clear[gi]),
                .o_pending   (w_pending[gi]),
                .o_tag       (w_tag[gi]),
                .o_cfg_ready (w_cfg_ready[gi]),
                .o_drop      (w_drop[gi])
            );
        end
    endgenerate

    assign cfg_ready_0 = w_cfg_ready[0];
    assign cfg_ready_1 = w_cfg_ready[1];

    // Granted requester's stream, selected by the registered owner.
    assign w_req_g  = r_owner ? wr_req_1  : wr_req_0;
    assign w_last_g = r_owner ? wr_last_1 : wr_last_0;
    assign w_data_g = r_owner ? wr_data_1 : wr_data_0;

    assign w_in_cfg  = (r_state == ST_CFG);
    assign w_in_data = (r_state == ST_DATA);

    assign grant         = (w_in_cfg || w_in_data) ? owner_onehot(r_owner) : 2'b00;
    assign config_paulse = w_in_cfg && config_ready;
    assign config_data   = config_paulse ? w_tag[r_owner] : '0;
    assign wr_req        = w_in_data && w_req_g;
    assign wr_data       = wr_req ? w_data_g : '0;
    assign wr_ready_0    = w_in_data && !r_owner && wr_ready;
    assign wr_ready_1    = w_in_data &&  r_owner && wr_ready;
    assign w_xfer        = wr_req && wr_ready;
    assign drop_err      = r_drop_err;

    // Next-state logic: grant, forward config, stream, release.
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_ptr_next   = r_ptr;
        w_count_next = r_count;
        w_clear      = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (|w_pending) begin
                    w_owner_next = (&w_pending) ? r_ptr : w_pending[1];
                    w_state_next = ST_CFG;
                end
            end
            ST_CFG: begin
                if (config_ready) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_xfer) begin
                    w_count_next = r_count + CNT_W'(1);
                    if (w_last_g || (r_count == CNT_W'(MAX_BURST - 1))) begin
                        w_state_next = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                w_clear[r_owner] = 1'b1;
                w_ptr_next       = ~r_owner;
                w_count_next     = '0;
                w_state_next     = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_ptr   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_ptr   <= w_ptr_next;
            r_count <= w_count_next;
        end
    end

    // Sticky flag for any config pulse dropped while a slot was busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_err <= 1'b0;
        end else if (|w_drop) begin
            r_drop_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Scoreboard bench for wr_port_arbiter: stimulus pushes expected config
// pulses and FIFO transfers; a negedge monitor pops and compares them.
module tb_wr_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_pulse_0 = 1'b0, cfg_pulse_1 = 1'b0;
    logic [3:0]  cfg_tag_0 = '0, cfg_tag_1 = '0;
    logic        cfg_ready_0, cfg_ready_1;
    logic        wr_req_0 = 1'b0, wr_req_1 = 1'b0;
    logic [31:0] wr_data_0 = '0, wr_data_1 = '0;
    logic        wr_last_0 = 1'b0, wr_last_1 = 1'b0;
    logic        wr_ready_0, wr_ready_1;
    logic        config_ready = 1'b1;
    logic        config_paulse;
    logic [3:0]  config_data;
    logic        wr_ready;
    logic        wr_req;
    logic [31:0] wr_data;
    logic [1:0]  grant;
    logic        drop_err;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    bit bp_en  = 1'b0;

    typedef struct packed { logic [1:0] g; logic [3:0]  t; } cfg_exp_t;
    typedef struct packed { logic [1:0] g; logic [31:0] d; } wr_exp_t;
    cfg_exp_t cfg_q[$];
    wr_exp_t  wr_q[$];

    wr_port_arbiter dut (
        .clk(clk), .rst(rst),
        .cfg_pulse_0(cfg_pulse_0), .cfg_pulse_1(cfg_pulse_1),
        .cfg_tag_0(cfg_tag_0), .cfg_tag_1(cfg_tag_1),
        .cfg_ready_0(cfg_ready_0), .cfg_ready_1(cfg_ready_1),
        .wr_req_0(wr_req_0), .wr_req_1(wr_req_1),
        .wr_data_0(wr_data_0), .wr_data_1(wr_data_1),
        .wr_last_0(wr_last_0), .wr_last_1(wr_last_1),
        .wr_ready_0(wr_ready_0), .wr_ready_1(wr_ready_1),
        .config_ready(config_ready), .config_paulse(config_paulse),
        .config_data(config_data),
        .wr_ready(wr_ready), .wr_req(wr_req), .wr_data(wr_data),
        .grant(grant), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // FIFO-side ready: steady high, or toggling 1,0,1,0 under back-pressure.
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            wr_ready = bp_en ? ~wr_ready : 1'b1;
        end
    end

    // Monitor: every observed config pulse / FIFO transfer is checked in order.
    always @(negedge clk) begin
        if (mon_en) begin
            if (config_paulse === 1'b1) begin
                if (cfg_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cfg_unexpected: got tag %0h want no pulse", config_data);
                end else begin
                    cfg_exp_t e;
                    e = cfg_q.pop_front();
                    $display("cfg  grant=%b tag=%0h", grant, config_data);
                    chk("cfg_grant_tag", {58'd0, grant, config_data}, {58'd0, e.g, e.t});
                end
            end
            if (wr_req === 1'b1 && wr_ready === 1'b1) begin
                if (wr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_unexpected: got data %0h want no transfer", wr_data);
                end else begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    $display("xfer grant=%b data=%08h", grant, wr_data);
                    chk("wr_grant_data", {30'd0, grant, wr_data}, {30'd0, e.g, e.d});
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        cfg_pulse_0 = 0; cfg_pulse_1 = 0; wr_req_0 = 0; wr_req_1 = 0;
        wr_last_0 = 0; wr_last_1 = 0; config_ready = 1; bp_en = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse(input int req, input logic [3:0] tag);
        if (req == 0) begin cfg_pulse_0 = 1; cfg_tag_0 = tag; end
        else          begin cfg_pulse_1 = 1; cfg_tag_1 = tag; end
        @(posedge clk); #1;
        cfg_pulse_0 = 0; cfg_pulse_1 = 0;
    endtask

    task automatic expect_words(input logic [1:0] g, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) wr_q.push_back('{g, base + 32'(k)});
    endtask

    // Requester-side stream driver; gives up after stall_limit idle cycles.
    task automatic drive_stream(input int req, input int n, input logic [31:0] base,
                                input bit last_at_end, input int stall_limit, output int sent);
        int stall = 0;
        logic rdy;
        sent = 0;
        while (sent < n && stall < stall_limit) begin
            if (req == 0) begin
                wr_req_0 = 1; wr_data_0 = base + 32'(sent);
                wr_last_0 = last_at_end && (sent == n - 1);
            end else begin
                wr_req_1 = 1; wr_data_1 = base + 32'(sent);
                wr_last_1 = last_at_end && (sent == n - 1);
            end
            @(negedge clk);
            rdy = (req == 0) ? wr_ready_0 : wr_ready_1;
            @(posedge clk); #1;
            if (rdy) begin sent++; stall = 0; end
            else stall++;
        end
        if (req == 0) begin wr_req_0 = 0; wr_last_0 = 0; end
        else          begin wr_req_1 = 0; wr_last_1 = 0; end
    endtask

    initial begin
        int sent, s0, s1, w;

        // Reset values
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_cfg_ready", {cfg_ready_1, cfg_ready_0}, 2'b11);
        chk("rst_config_out", {config_paulse, config_data}, 5'd0);
        chk("rst_wr_out", {wr_req, wr_data}, 33'd0);
        chk("rst_wr_ready_x", {wr_ready_1, wr_ready_0}, 2'b00);
        chk("rst_drop_err", drop_err, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        mon_en = 1'b1;

        // Single request, 3 words with last
        cfg_q.push_back('{2'b01, 4'h3});
        expect_words(2'b01, 32'h1000_0000, 3);
        pulse(0, 4'h3);
        chk("single_cfg_ready_busy", cfg_ready_0, 1'b0);
        drive_stream(0, 3, 32'h1000_0000, 1, 60, sent);
        chk("single_sent", sent, 3);
        @(negedge clk);
        chk("single_release_grant", grant, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_cfg_ready_after", cfg_ready_0, 1'b1);

        // Simultaneous requests after reset: 0 first, then 1, then ptr back to 0
        do_reset();
        cfg_q.push_back('{2'b01, 4'h1});
        cfg_q.push_back('{2'b10, 4'h2});
        expect_words(2'b01, 32'h2000_0000, 2);
        expect_words(2'b10, 32'h2100_0000, 2);
        cfg_pulse_1 = 1; cfg_tag_1 = 4'h2;
        pulse(0, 4'h1);
        fork
            drive_stream(0, 2, 32'h2000_0000, 1, 60, s0);
            drive_stream(1, 2, 32'h2100_0000, 1, 60, s1);
        join
        chk("both_sent0", s0, 2);
        chk("both_sent1", s1, 2);
        repeat (2) @(posedge clk); #1;
        cfg_q.push_back('{2'b01, 4'h5});
        cfg_q.push_back('{2'b10, 4'h6});
        expect_words(2'b01, 32'h2200_0000, 1);
        expect_words(2'b10, 32'h2300_0000, 1);
        cfg_pulse_1 = 1; cfg_tag_1 = 4'h6;
        pulse(0, 4'h5);
        fork
            drive_stream(0, 1, 32'h2200_0000, 1, 60, s0);
            drive_stream(1, 1, 32'h2300_0000, 1, 60, s1);
        join
        chk("ptr_sent0", s0, 1);
        chk("ptr_sent1", s1, 1);

        // Forced release at MAX_BURST, then re-request for the remainder
        do_reset();
        cfg_q.push_back('{2'b10, 4'h5});
        expect_words(2'b10, 32'h3000_0000, 16);
        pulse(1, 4'h5);
        drive_stream(1, 20, 32'h3000_0000, 0, 8, sent);
        chk("burst_sent", sent, 16);
        wr_req_1 = 1; wr_data_1 = 32'h3000_0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("burst_wr_ready_1_low", {grant, wr_ready_1, wr_req}, 4'b0000);
        end
        @(posedge clk); #1 wr_req_1 = 0;
        cfg_q.push_back('{2'b10, 4'h6});
        expect_words(2'b10, 32'h3000_0010, 4);
        pulse(1, 4'h6);
        drive_stream(1, 4, 32'h3000_0010, 1, 60, sent);
        chk("burst_rest_sent", sent, 4);

        // config_ready held low in CFG
        do_reset();
        config_ready = 0;
        cfg_q.push_back('{2'b10, 4'hC});
        expect_words(2'b10, 32'h4000_0000, 2);
        pulse(1, 4'hC);
        w = 0;
        do @(negedge clk); while (grant == 2'b00 && ++w < 20);
        chk("hold_reach_cfg", grant, 2'b10);
        for (int k = 0; k < 5; k++) begin
            chk("hold_no_pulse", config_paulse, 1'b0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1 config_ready = 1;
        drive_stream(1, 2, 32'h4000_0000, 1, 60, sent);
        chk("hold_sent", sent, 2);

        // Back-pressure: wr_ready 1,0,1,0
        do_reset();
        cfg_q.push_back('{2'b01, 4'hA});
        expect_words(2'b01, 32'h5000_0000, 6);
        pulse(0, 4'hA);
        bp_en = 1;
        drive_stream(0, 6, 32'h5000_0000, 1, 8, sent);
        chk("bp_sent", sent, 6);
        bp_en = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_idle", {grant, cfg_ready_0}, 3'b001);

        // Dropped pulse keeps original tag; drop_err sticky
        do_reset();
        cfg_q.push_back('{2'b01, 4'h7});
        expect_words(2'b01, 32'h6000_0000, 1);
        pulse(0, 4'h7);
        pulse(0, 4'h9);
        @(negedge clk);
        chk("drop_err_set", drop_err, 1'b1);
        drive_stream(0, 1, 32'h6000_0000, 1, 60, sent);
        chk("drop_sent", sent, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("drop_err_sticky", drop_err, 1'b1);

        // Reset in DATA
        do_reset();
        chk("drop_err_cleared", drop_err, 1'b0);
        cfg_q.push_back('{2'b01, 4'h8});
        expect_words(2'b01, 32'h7000_0000, 2);
        pulse(0, 4'h8);
        wr_req_0 = 1; wr_data_0 = 32'h7000_0000;
        w = 0;
        do @(negedge clk); while (!wr_ready_0 && ++w < 30);
        chk("rstd_reach_data", wr_ready_0, 1'b1);
        @(posedge clk); #1;
        wr_data_0 = 32'h7000_0001;
        rst = 1;
        @(posedge clk); #1;
        wr_data_0 = 32'h7000_0002;
        @(negedge clk);
        chk("rstd_grant", grant, 2'b00);
        chk("rstd_wr_out", {wr_req, wr_data}, 33'd0);
        chk("rstd_config_out", {config_paulse, config_data}, 5'd0);
        chk("rstd_ready", {cfg_ready_1, cfg_ready_0, wr_ready_1, wr_ready_0}, 4'b1100);
        @(posedge clk); #1;
        rst = 0; wr_req_0 = 0;
        repeat (2) @(posedge clk);

        chk("cfg_q_drained", cfg_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
